// File: rtl/pipe_fifo_buffer_pkg.sv
// Shared stage-buffer definitions: flush/hold priority encoding and DEPTH range limits.
package pipe_fifo_buffer_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 16;
    localparam int N_MAX     = 128;

    typedef enum logic [1:0] {
        ACT_RESET = 2'd0,
        ACT_FLUSH = 2'd1,
        ACT_HOLD  = 2'd2,
        ACT_RUN   = 2'd3
    } pipe_act_e;

    // Per-edge priority: reset > flush > hold > normal push/pop.
    function automatic pipe_act_e pipe_act(input logic reset, input logic flush, input logic hold);
        if (reset)      return ACT_RESET;
        else if (flush) return ACT_FLUSH;
        else if (hold)  return ACT_HOLD;
        else            return ACT_RUN;
    endfunction

endpackage

// File: rtl/pipe_fifo_buffer_ptr.sv
// Read/write pointers, occupancy count and full/empty flags for pipe_fifo_buffer.
import pipe_fifo_buffer_pkg::*;

module pipe_fifo_ptr #(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          hold,
    input  logic          push,
    input  logic          pop,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    pipe_act_e act;

    assign act   = pipe_act(reset, flush, hold);
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clock) begin
        case (act)
            ACT_RESET, ACT_FLUSH: begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end
            ACT_HOLD: ;
            default: begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/pipe_fifo_buffer.sv
// Elastic valid/ready FIFO stage between pipeline stages, with flush and hold.
// Optional PIPE_FIFO_BYPASS_EN: zero-latency forward of in_data when the buffer is empty.
import pipe_fifo_buffer_pkg::*;

module pipe_fifo_buffer #(
    parameter int N     = 16,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          hold,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [CW-1:0] count,
    output logic          overrun
);

    localparam int PW = $clog2(DEPTH);

    generate
        if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0 || N < 1 || N > N_MAX) begin : g_bad_cfg
            $error("pipe_fifo_buffer: unsupported N/DEPTH configuration");
        end
    endgenerate

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, run;
    logic          push, pop, store, ptr_pop;
    logic [N-1:0]  head;

    assign run      = (pipe_act(reset, flush, hold) == ACT_RUN);
    assign in_ready = run & ~full;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign ptr_pop  = pop & ~empty;

`ifdef PIPE_FIFO_BYPASS_EN
    logic bypass;
    assign bypass    = run & empty;
    assign out_valid = run & (~empty | in_valid);
    assign head      = bypass ? in_data : mem[rd_ptr];
    // A word consumed in the same cycle it arrives never touches storage.
    assign store     = push & ~(bypass & out_ready);
`else
    assign out_valid = run & ~empty;
    assign head      = mem[rd_ptr];
    assign store     = push;
`endif

    assign out_data = out_valid ? head : '0;

    pipe_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clock  (clock),
        .reset  (reset),
        .flush  (flush),
        .hold   (hold),
        .push   (store),
        .pop    (ptr_pop),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (store) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Sticky producer-side protocol flag; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset)
            overrun <= 1'b0;
        else if (in_valid & ~in_ready & ~hold & ~flush)
            overrun <= 1'b1;
    end

endmodule

// File: tb/tb_pipe_fifo_buffer.sv
// Directed self-checking bench for pipe_fifo_buffer (N=16, DEPTH=4).
module tb_pipe_fifo_buffer;

    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset, flush, hold;
    logic          in_valid, in_ready, out_valid, out_ready, overrun;
    logic [N-1:0]  in_data, out_data;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    pipe_fifo_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; hold = 1'b0;
        in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;

        // T1: reset held for three cycles with in_valid asserted
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_count", 32'(count), 0);
            chk("rst_out_data", 32'(out_data), 0);
            chk("rst_overrun", 32'(overrun), 0);
            if (i < 2) tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);
        chk("rel_out_valid", 32'(out_valid), 0);

        // T2: fill to DEPTH with consumer stalled
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1; in_data = 16'h1111 * 16'(k + 1);
            #1;
            chk("fill_in_ready", 32'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_head", 32'(out_data), 32'h1111);

        // T2: drain in order on consecutive cycles
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            chk("drain_valid", 32'(out_valid), 1);
            chk("drain_data", 32'(out_data), 32'(16'h1111 * 16'(k + 1)));
            tick();
        end
        out_ready = 1'b0;
        #1;
        chk("drained_count", 32'(count), 0);
        chk("drained_valid", 32'(out_valid), 0);
        chk("drained_data", 32'(out_data), 0);
        chk("no_overrun_yet", 32'(overrun), 0);

        // refill with A001..A004
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1; in_data = 16'hA001 + 16'(k);
            tick();
        end

        // T3: full with in_valid and out_ready -> pop only
        in_valid = 1'b1; in_data = 16'hB005; out_ready = 1'b1;
        #1;
        chk("t3_in_ready", 32'(in_ready), 0);
        chk("t3_head", 32'(out_data), 32'hA001);
        tick();
        in_data = 16'hB006;
        #1;
        chk("t3_count_pop", 32'(count), 3);
        chk("t3_overrun", 32'(overrun), 1);
        chk("t3_in_ready2", 32'(in_ready), 1);
        chk("t3_head2", 32'(out_data), 32'hA002);
        tick();
        #1;
        chk("t3_count_pp", 32'(count), 3);
        chk("t3_head3", 32'(out_data), 32'hA003);

        // T4: flush with both handshakes requested
        flush = 1'b1; in_data = 16'hDEAD;
        #1;
        chk("t4_in_ready", 32'(in_ready), 0);
        chk("t4_out_valid", 32'(out_valid), 0);
        chk("t4_out_data", 32'(out_data), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("t4_count", 32'(count), 0);
        chk("t4_valid_after", 32'(out_valid), 0);
        in_valid = 1'b1; in_data = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        #1;
        chk("t4_beef_valid", 32'(out_valid), 1);
        chk("t4_beef_data", 32'(out_data), 32'hBEEF);
        chk("t4_beef_count", 32'(count), 1);

        // T5: hold with count=2 for five cycles
        in_valid = 1'b1; in_data = 16'hC001;
        tick();
        hold = 1'b1; in_data = 16'hC002; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_count", 32'(count), 2);
            chk("t5_in_ready", 32'(in_ready), 0);
            chk("t5_out_valid", 32'(out_valid), 0);
            tick();
        end
        hold = 1'b0; in_valid = 1'b0;
        #1;
        chk("t5_head", 32'(out_data), 32'hBEEF);
        tick();
        #1;
        chk("t5_head2", 32'(out_data), 32'hC001);
        tick();
        out_ready = 1'b0;
        #1;
        chk("t5_empty", 32'(count), 0);

        // T6: empty buffer, word arrives while consumer is ready
        in_valid = 1'b1; in_data = 16'hA5A5; out_ready = 1'b1;
        #1;
`ifdef PIPE_FIFO_BYPASS_EN
        chk("t6_byp_valid", 32'(out_valid), 1);
        chk("t6_byp_data", 32'(out_data), 32'hA5A5);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t6_byp_count", 32'(count), 0);
        chk("t6_byp_after", 32'(out_valid), 0);
`else
        chk("t6_valid_now", 32'(out_valid), 0);
        chk("t6_data_now", 32'(out_data), 0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("t6_valid_next", 32'(out_valid), 1);
        chk("t6_data_next", 32'(out_data), 32'hA5A5);
        chk("t6_count_next", 32'(count), 1);
`endif
        chk("overrun_sticky", 32'(overrun), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
